// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: note pitches, FSM encoding and
// the special period codes stored in the jingle ROM.
package tone_pkg;

  // Two octaves of the natural scale, in Hz
  typedef enum int {
    NOTE_C4 = 262, NOTE_D4 = 294, NOTE_E4 = 330, NOTE_F4 = 349,
    NOTE_G4 = 392, NOTE_A4 = 440, NOTE_B4 = 494,
    NOTE_C5 = 523, NOTE_D5 = 587, NOTE_E5 = 659, NOTE_F5 = 698,
    NOTE_G5 = 784, NOTE_A5 = 880, NOTE_B5 = 988
  } note_hz_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Periods 0 and 1 cannot produce a square wave, so both mean rest
  localparam int REST_CODE     = 0;
  localparam int REST_CODE_ALT = 1;

  // The terminator is an all-ones period of the given width
  function automatic logic [31:0] term_code(input int per_w);
    return 32'hFFFF_FFFF >> (32 - per_w);
  endfunction

  function automatic int period_of(input int clk_pre, input int hz);
    return clk_pre / hz;
  endfunction

endpackage

// File: rtl/tone_rom.sv
// Jingle table: maps (jingle, step) to a tone period in clocks.
// Purely combinational; unused steps and unknown jingles fall back safely.
module tone_rom
  import tone_pkg::*;
#(
  parameter int CLK_PRE = 50_000_000,
  parameter int PER_W   = 17,
  parameter int JW      = 2,
  parameter int SW      = 3
) (
  input  logic [JW-1:0]    jingle,
  input  logic [SW-1:0]    step,
  output logic [PER_W-1:0] period
);

  localparam logic [PER_W-1:0] P_DO   = PER_W'(period_of(CLK_PRE, NOTE_C5));
  localparam logic [PER_W-1:0] P_MI   = PER_W'(period_of(CLK_PRE, NOTE_E5));
  localparam logic [PER_W-1:0] P_FA   = PER_W'(period_of(CLK_PRE, NOTE_F5));
  localparam logic [PER_W-1:0] P_SO   = PER_W'(period_of(CLK_PRE, NOTE_G5));
  localparam logic [PER_W-1:0] P_LA   = PER_W'(period_of(CLK_PRE, NOTE_A5));
  localparam logic [PER_W-1:0] P_REST = PER_W'(REST_CODE);
  localparam logic [PER_W-1:0] P_TERM = PER_W'(term_code(PER_W));

  // Jingle 0 is also the default, which covers out-of-range selections
  always_comb begin
    period = P_TERM;
    case (jingle)
      JW'(1): begin
        case (step)
          SW'(0):  period = P_SO;
          SW'(1):  period = P_MI;
          SW'(2):  period = P_DO;
          default: period = P_TERM;
        endcase
      end
      JW'(2): begin
        case (step)
          SW'(0):  period = P_LA;
          SW'(1):  period = P_REST;
          SW'(2):  period = P_LA;
          default: period = P_TERM;
        endcase
      end
      JW'(3): begin
        case (step)
          SW'(0):  period = P_FA;
          default: period = P_TERM;
        endcase
      end
      default: begin
        case (step)
          SW'(0):  period = P_DO;
          SW'(1):  period = P_MI;
          SW'(2):  period = P_SO;
          default: period = P_TERM;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays short buzzer jingles: steps through ROM periods one note slot at a
// time and drives an active-low PWM whose duty is set by the latched volume.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_PRE       = 50_000_000,
  parameter int NOTE_TICKS    = 15_000_000,
  parameter int SEQ_LEN       = 8,
  parameter int NUM_JINGLES   = 4,
  parameter int PER_W         = 17,
  parameter int VOL_MIN_SHIFT = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trig,
  input  logic [$clog2(NUM_JINGLES)-1:0] jingle_sel,
  input  logic [1:0]                     vol,
  input  logic                           abort,
  output logic                           pwm,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(SEQ_LEN)-1:0]     note_idx
);

  localparam int JW = $clog2(NUM_JINGLES);
  localparam int SW = $clog2(SEQ_LEN);
  localparam int DW = $clog2(NOTE_TICKS);

  localparam logic [DW-1:0]    DUR_LAST  = DW'(NOTE_TICKS - 1);
  localparam logic [DW-1:0]    GAP_START = DW'(NOTE_TICKS - (NOTE_TICKS >> 2));
  localparam logic [SW-1:0]    STEP_LAST = SW'(SEQ_LEN - 1);
  localparam logic [PER_W-1:0] TERM      = PER_W'(term_code(PER_W));

  state_t           state;
  logic [SW-1:0]    step;
  logic [PER_W-1:0] tone_cnt;
  logic [DW-1:0]    dur_cnt;
  logic [JW-1:0]    sel_l;
  logic [1:0]       vol_l;

  logic [PER_W-1:0] period;
  logic [PER_W-1:0] duty;
  logic [5:0]       shamt;
  logic             is_rest;
  logic             is_term;
  logic             tone_on;

  tone_rom #(
    .CLK_PRE (CLK_PRE),
    .PER_W   (PER_W),
    .JW      (JW),
    .SW      (SW)
  ) u_rom (
    .jingle (sel_l),
    .step   (step),
    .period (period)
  );

  assign is_rest = (period == PER_W'(REST_CODE)) || (period == PER_W'(REST_CODE_ALT));
  assign is_term = (period == TERM);
  assign shamt   = 6'(VOL_MIN_SHIFT) + 6'(vol_l);
  assign duty    = period >> shamt;

  // A zero duty never satisfies tone_cnt < duty, so such notes stay silent
  assign tone_on = (state == ST_PLAY) && !is_rest && !is_term &&
                   (dur_cnt < GAP_START) && (tone_cnt < duty);

  assign busy     = (state == ST_PLAY);
  assign done     = (state == ST_FINISH);
  assign note_idx = busy ? step : '0;

  // Abort beats trig; trig from IDLE or PLAY (re)starts from step 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      step     <= '0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      sel_l    <= '0;
      vol_l    <= '0;
      pwm      <= 1'b1;
    end else if (abort) begin
      state    <= ST_IDLE;
      step     <= '0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      pwm      <= 1'b1;
    end else begin
      pwm <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            sel_l    <= jingle_sel;
            vol_l    <= vol;
            step     <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (trig) begin
            sel_l    <= jingle_sel;
            vol_l    <= vol;
            step     <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
          end else if (is_term) begin
            state <= ST_FINISH;
          end else begin
            pwm <= !tone_on;
            if (dur_cnt == DUR_LAST) begin
              dur_cnt  <= '0;
              tone_cnt <= '0;
              if (step == STEP_LAST) begin
                state <= ST_FINISH;
              end else begin
                step <= step + 1'b1;
              end
            end else begin
              dur_cnt <= dur_cnt + 1'b1;
              if (!is_rest) begin
                tone_cnt <= (tone_cnt >= period - 1'b1) ? '0 : tone_cnt + 1'b1;
              end
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a playback-timeline model checked
// every cycle, plus directed per-note pulse counts and randomized traffic.
module tb_tone_sequencer;

  localparam int CLK_PRE    = 5230;
  localparam int NOTE_TICKS = 40;
  localparam int GAP        = NOTE_TICKS - NOTE_TICKS / 4;
  localparam int MAX_STEPS  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] jingle_sel = 2'd0;
  logic [1:0] vol = 2'd0;
  logic       pwm;
  logic       busy;
  logic       done;
  logic [2:0] note_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_play = 0;
  int m_pc   = 0;
  int m_sel  = 0;
  int m_vol  = 0;
  int m_pwm  = 1;
  int u_kind, u_step, u_aud;
  int c_kind, c_step, c_aud;

  // directed measurement results
  int ms_busy, ms_done, ms_last, ms_first_busy;
  int ms_low [MAX_STEPS];

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_PRE    (CLK_PRE),
    .NOTE_TICKS (NOTE_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .jingle_sel (jingle_sel),
    .vol        (vol),
    .abort      (abort),
    .pwm        (pwm),
    .busy       (busy),
    .done       (done),
    .note_idx   (note_idx)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Note frequency in Hz per (jingle, step); 0 is a rest, -1 ends the jingle
  function automatic int note_hz(input int j, input int s);
    case (j)
      1: case (s) 0: return 784; 1: return 659; 2: return 523; default: return -1; endcase
      2: case (s) 0: return 880; 1: return 0;   2: return 880; default: return -1; endcase
      3: case (s) 0: return 698; default: return -1; endcase
      default: case (s) 0: return 523; 1: return 659; 2: return 784; default: return -1; endcase
    endcase
  endfunction

  // What playback looks like pc cycles after the start edge:
  // kind 1 = note slot, 2 = terminator cycle, 3 = done cycle, 0 = over
  function automatic void timeline(input int j, input int v, input int pc,
                                   output int kind, output int step, output int aud);
    int n, slot, k, hz, p, duty, tail;
    n = 0;
    while (n < MAX_STEPS && note_hz(j, n) >= 0) n++;
    kind = 0; step = 0; aud = 0;
    slot = pc / NOTE_TICKS;
    k    = pc % NOTE_TICKS;
    if (slot < n) begin
      kind = 1;
      step = slot;
      hz   = note_hz(j, slot);
      p    = (hz > 0) ? CLK_PRE / hz : 0;
      duty = p >> (1 + v);
      if (p > 1 && k < GAP && (k % p) < duty) aud = 1;
    end else begin
      tail = pc - n * NOTE_TICKS;
      if (n < MAX_STEPS) begin
        if (tail == 0) begin kind = 2; step = n; end
        else if (tail == 1) kind = 3;
      end else if (tail == 0) begin
        kind = 3;
      end
    end
  endfunction

  // Reference model: advances the playback position on each clock edge
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_play = 0; m_pc = 0; m_sel = 0; m_vol = 0; m_pwm = 1;
      end else begin
        u_kind = 0; u_step = 0; u_aud = 0;
        if (m_play != 0) timeline(m_sel, m_vol, m_pc, u_kind, u_step, u_aud);
        if (abort) begin
          m_play = 0; m_pwm = 1;
        end else if (trig && u_kind != 3) begin
          m_play = 1; m_pc = 0; m_sel = int'(jingle_sel); m_vol = int'(vol); m_pwm = 1;
        end else if (m_play != 0) begin
          m_pwm = (u_kind == 1) ? (u_aud == 0 ? 1 : 0) : 1;
          if (u_kind == 3) m_play = 0;
          else m_pc++;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      c_kind = 0; c_step = 0; c_aud = 0;
      if (m_play != 0) timeline(m_sel, m_vol, m_pc, c_kind, c_step, c_aud);
      checkOutput("busy", int'(busy), (c_kind == 1 || c_kind == 2) ? 1 : 0);
      checkOutput("done", int'(done), (c_kind == 3) ? 1 : 0);
      checkOutput("note_idx", int'(note_idx), (c_kind == 1 || c_kind == 2) ? c_step : 0);
      checkOutput("pwm", int'(pwm), m_pwm);
    end
  end

  task automatic applyStimulus(input int sel, input int v);
    @(posedge clk); #2;
    jingle_sel = 2'(sel);
    vol        = 2'(v);
    trig       = 1'b1;
    @(posedge clk); #2;
    trig = 1'b0;
  endtask

  task automatic measure(input int limit);
    ms_busy = 0; ms_done = 0; ms_last = 0; ms_first_busy = 0;
    for (int i = 0; i < MAX_STEPS; i++) ms_low[i] = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (c == 0) ms_first_busy = int'(busy);
      if (busy) begin
        ms_busy++;
        ms_last = int'(note_idx);
        if (!pwm) ms_low[note_idx]++;
      end
      if (done) ms_done++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_pwm", int'(pwm), 1);

    $display("[TB] jingle 0, loudest");
    applyStimulus(0, 0);
    measure(130);
    checkOutput("j0_first_busy", ms_first_busy, 1);
    checkOutput("j0_busy_cycles", ms_busy, 121);
    checkOutput("j0_do_low", ms_low[0], 15);
    checkOutput("j0_mi_low", ms_low[1], 14);
    checkOutput("j0_so_low", ms_low[2], 15);
    checkOutput("j0_done", ms_done, 1);

    $display("[TB] jingle 2, vol 1");
    applyStimulus(2, 1);
    measure(130);
    checkOutput("j2_busy_cycles", ms_busy, 121);
    checkOutput("j2_la_low", ms_low[0], 6);
    checkOutput("j2_rest_low", ms_low[1], 0);
    checkOutput("j2_la2_low", ms_low[2], 6);
    checkOutput("j2_done", ms_done, 1);

    $display("[TB] jingle 3, single note");
    applyStimulus(3, 0);
    measure(60);
    checkOutput("j3_busy_cycles", ms_busy, 41);
    checkOutput("j3_fa_low", ms_low[0], 14);
    checkOutput("j3_term_idx", ms_last, 1);
    checkOutput("j3_done", ms_done, 1);

    $display("[TB] jingle 1, vol 3 (zero duty)");
    applyStimulus(1, 3);
    measure(130);
    checkOutput("j1v3_busy_cycles", ms_busy, 121);
    checkOutput("j1v3_so_low", ms_low[0], 0);
    checkOutput("j1v3_mi_low", ms_low[1], 0);
    checkOutput("j1v3_done", ms_done, 1);

    $display("[TB] retrigger mid-step");
    applyStimulus(0, 0);
    repeat (60) @(posedge clk);
    applyStimulus(1, 0);
    measure(130);
    checkOutput("retrig_busy_cycles", ms_busy, 121);
    checkOutput("retrig_so_low", ms_low[0], 15);
    checkOutput("retrig_done", ms_done, 1);

    $display("[TB] abort mid-note");
    applyStimulus(0, 0);
    repeat (20) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_pwm", int'(pwm), 1);
    measure(150);
    checkOutput("abort_done", ms_done, 0);
    checkOutput("abort_busy_cycles", ms_busy, 0);

    $display("[TB] reset mid-note");
    applyStimulus(2, 0);
    repeat (12) @(posedge clk);
    #2;
    checkOutput("pre_rst_pwm", int'(pwm), 0);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_pwm", int'(pwm), 1);
    checkOutput("rst_note_idx", int'(note_idx), 0);
    checkOutput("rst_done", int'(done), 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      @(posedge clk); #2;
      jingle_sel = 2'($urandom_range(0, 3));
      vol        = 2'($urandom_range(0, 3));
      if (r < 5) begin
        trig  = 1'b1;
        abort = ($urandom_range(0, 9) == 0);
      end else if (r == 5) begin
        abort = 1'b1;
      end
      @(posedge clk); #2;
      trig  = 1'b0;
      abort = 1'b0;
      jingle_sel = 2'($urandom_range(0, 3));
      vol        = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 80)) @(posedge clk);
    end

    repeat (200) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
